// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C slave with register pointer and a byte-wide register-file port
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         PTR_W      = 8,
  parameter int         FILT_LEN   = 3,
  parameter bit         AUTO_INC   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_oen,
  output logic [PTR_W-1:0] rf_addr,
  output logic [7:0]       rf_wdata,
  output logic             rf_we,
  output logic             rf_re,
  input  logic [7:0]       rf_rdata,
  output logic             busy,
  output logic             addressed,
  output logic             rd_mode
);
  localparam int CW = $clog2(FILT_LEN + 1);
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, flt, flt_p;
  logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [6:0] shreg, shreg_n, tx, tx_n;
  logic [7:0] rx_byte;
  logic [PTR_W-1:0] ptr, ptr_n, addr_n;
  logic [7:0] wdata_n;
  logic oen_n, we_n, re_n, busy_n, addressed_n, rd_mode_n, ack_pend, ack_pend_n, load_pend, load_n;
  assign sda_o = 1'b0;
  // two-flop synchroniser on both pads plus previous filtered levels for edge detect
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      flt_p <= '1;
    end else begin
      s1 <= {scl_i, sda_i};
      s2 <= s1;
      flt_p <= flt;
    end
  for (genvar g = 0; g < 2; g++) begin : g_flt
    logic [CW-1:0] cnt;
    logic q;
    assign flt[g] = q;
    // filtered level flips only after FILT_LEN consecutive differing samples
    always_ff @(posedge clk)
      if (rst) begin
        cnt <= '0;
        q <= 1'b1;
      end else if (s2[g] == q) cnt <= '0;
      else if (cnt == CW'(FILT_LEN - 1)) begin
        cnt <= '0;
        q <= s2[g];
      end else cnt <= cnt + 1'b1;
  end
  assign scl_f = flt[1];
  assign sda_f = flt[0];
  assign scl_rise = scl_f & ~flt_p[1];
  assign scl_fall = ~scl_f & flt_p[1];
  assign start_c = scl_f & flt_p[1] & flt_p[0] & ~sda_f;
  assign stop_c = scl_f & flt_p[1] & ~flt_p[0] & sda_f;
  assign rx_byte = {shreg, sda_f};
  // bus protocol: START/STOP first, then read-data load, bit sampling on SCL rise, SDA drive on SCL fall
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    tx_n = tx;
    ptr_n = ptr;
    oen_n = sda_oen;
    we_n = 1'b0;
    re_n = 1'b0;
    load_n = 1'b0;
    addr_n = rf_addr;
    wdata_n = rf_wdata;
    busy_n = busy;
    addressed_n = addressed;
    rd_mode_n = rd_mode;
    ack_pend_n = ack_pend;
    if (start_c) begin
      state_n = DEV_ADDR;
      bit_cnt_n = '0;
      ack_pend_n = 1'b0;
      oen_n = 1'b1;
      busy_n = 1'b1;
      addressed_n = 1'b0;
    end else if (stop_c) begin
      state_n = IDLE;
      ack_pend_n = 1'b0;
      oen_n = 1'b1;
      busy_n = 1'b0;
      addressed_n = 1'b0;
    end else begin
      if (load_pend) begin
        tx_n = rf_rdata[6:0];
        oen_n = rf_rdata[7];
      end
      if (scl_rise) begin
        shreg_n = rx_byte[6:0];
        bit_cnt_n = bit_cnt + 4'd1;
        case (state)
          DEV_ADDR: if (bit_cnt == 4'd7) begin
            if (rx_byte[7:1] == SLAVE_ADDR) ack_pend_n = 1'b1;
            else state_n = WAIT_STOP;
          end
          PTR: if (bit_cnt == 4'd7) begin
            ptr_n = rx_byte[PTR_W-1:0];
            ack_pend_n = 1'b1;
          end
          WR_DATA: if (bit_cnt == 4'd7) begin
            we_n = 1'b1;
            addr_n = ptr;
            wdata_n = rx_byte;
            ack_pend_n = 1'b1;
          end
          RD_ACK: if (!sda_f) begin
            ack_pend_n = 1'b1;
            ptr_n = ptr + PTR_W'(AUTO_INC);
          end else state_n = WAIT_STOP;
          default: ;
        endcase
      end
      if (scl_fall) begin
        case (state)
          DEV_ADDR, PTR, WR_DATA: if (ack_pend) begin
            ack_pend_n = 1'b0;
            oen_n = 1'b0;
            state_n = state == DEV_ADDR ? DEV_ACK : state == PTR ? PTR_ACK : WR_ACK;
            addressed_n = state == DEV_ADDR ? 1'b1 : addressed;
            rd_mode_n = state == DEV_ADDR ? shreg[0] : rd_mode;
          end
          DEV_ACK: begin
            oen_n = 1'b1;
            bit_cnt_n = '0;
            state_n = rd_mode ? RD_DATA : PTR;
            re_n = rd_mode;
            load_n = rd_mode;
            addr_n = rd_mode ? ptr : rf_addr;
          end
          PTR_ACK, WR_ACK: begin
            oen_n = 1'b1;
            bit_cnt_n = '0;
            state_n = WR_DATA;
            ptr_n = state == WR_ACK ? ptr + PTR_W'(AUTO_INC) : ptr;
          end
          RD_DATA: if (bit_cnt == 4'd8) begin
            oen_n = 1'b1;
            bit_cnt_n = '0;
            state_n = RD_ACK;
          end else begin
            oen_n = tx[6];
            tx_n = {tx[5:0], 1'b0};
          end
          RD_ACK: if (ack_pend) begin
            ack_pend_n = 1'b0;
            re_n = 1'b1;
            load_n = 1'b1;
            addr_n = ptr;
            bit_cnt_n = '0;
            state_n = RD_DATA;
          end
          default: ;
        endcase
      end
    end
  end
  // state and datapath registers; reset releases SDA on the same edge
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      tx <= '0;
      ptr <= '0;
      sda_oen <= 1'b1;
      rf_we <= 1'b0;
      rf_re <= 1'b0;
      load_pend <= 1'b0;
      rf_addr <= '0;
      rf_wdata <= '0;
      busy <= 1'b0;
      addressed <= 1'b0;
      rd_mode <= 1'b0;
      ack_pend <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      tx <= tx_n;
      ptr <= ptr_n;
      sda_oen <= oen_n;
      rf_we <= we_n;
      rf_re <= re_n;
      load_pend <= load_n;
      rf_addr <= addr_n;
      rf_wdata <= wdata_n;
      busy <= busy_n;
      addressed <= addressed_n;
      rd_mode <= rd_mode_n;
      ack_pend <= ack_pend_n;
    end
endmodule
